// File: rtl/lsu_pkg.sv
// Shared types and defaults for the load/store SRAM controller.
// Optional build macro LSU_MISALIGN_TRAP_EN is consumed by lsu_sram_ctrl.
package lsu_pkg;

    localparam int LSU_MEM_WORDS = 16384;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ISSUE   = 2'b01,
        RD_WAIT = 2'b10,
        RESP    = 2'b11
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte-enable mask, store data replication and
// load data shift plus sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  lsu_size_e   i_size,
    input  logic [1:0]  i_off,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_bmask,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [31:0] w_shift;

    function automatic logic [31:0] extend(input logic [31:0] v, input lsu_size_e sz,
                                           input logic uns);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = signed'(v[7:0]);
        h = signed'(v[15:0]);
        case (sz)
            SZ_BYTE: extend = uns ? {24'h0, v[7:0]}  : {{24{b[7]}}, b};
            SZ_HALF: extend = uns ? {16'h0, v[15:0]} : {{16{h[15]}}, h};
            default: extend = v;
        endcase
    endfunction

    // Lane 0 of the shifted word always holds the addressed byte.
    assign w_shift = i_rdata >> {i_off, 3'b000};

    always_comb begin
        o_bmask = 4'b1111;
        o_wdata = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                o_bmask = 4'b0001 << i_off;
                o_wdata = {4{i_wdata[7:0]}};
            end
            SZ_HALF: begin
                o_bmask = 4'b0011 << i_off;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                o_bmask = 4'b1111;
                o_wdata = i_wdata;
            end
        endcase
        o_rdata = extend(w_shift, i_size, i_unsigned);
    end

endmodule

// File: rtl/lsu_sram_ctrl.sv
// Single-outstanding load/store controller for a synchronous 32-bit SRAM.
// Define LSU_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors.
module lsu_sram_ctrl
    import lsu_pkg::*;
#(
    parameter int AW        = 32,
    parameter int MEM_WORDS = LSU_MEM_WORDS
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic [AW-1:0] i_req_addr,
    input  logic          i_req_we,
    input  logic [1:0]    i_req_size,
    input  logic          i_req_unsigned,
    input  logic [31:0]   i_req_wdata,
    output logic          o_rsp_valid,
    input  logic          i_rsp_ready,
    output logic [31:0]   o_rsp_rdata,
    output logic          o_rsp_err,
    output logic [AW-1:0] o_mem_addr,
    output logic [31:0]   o_mem_wdata,
    output logic          o_mem_cs,
    output logic          o_mem_wren,
    output logic [3:0]    o_mem_bmask,
    input  logic [31:0]   i_mem_rdata
);

    lsu_state_e    r_state;
    lsu_state_e    w_next;
    logic          r_live;
    logic [AW-1:0] r_addr;
    logic          r_we;
    lsu_size_e     r_size;
    logic          r_unsigned;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rsp_rdata;
    logic          r_rsp_err;

    logic [AW-1:0] w_eff_addr;
    logic [AW-1:0] w_word_idx;
    logic          w_misalign;
    logic          w_err;
    logic          w_issue;
    logic          w_accept;
    logic [3:0]    w_bmask;
    logic [31:0]   w_wdata_rep;
    logic [31:0]   w_load_data;

    always_comb begin
        w_eff_addr = r_addr;
        w_misalign = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        w_misalign = ((r_size == SZ_HALF) && r_addr[0]) ||
                     ((r_size == SZ_WORD) && (r_addr[1:0] != 2'b00));
`else
        if (r_size == SZ_HALF) begin
            w_eff_addr[0] = 1'b0;
        end else if (r_size == SZ_WORD) begin
            w_eff_addr[1:0] = 2'b00;
        end
`endif
    end

    assign w_word_idx = {2'b00, r_addr[AW-1:2]};
    assign w_err      = (r_size == SZ_ILL) || (w_word_idx >= AW'(MEM_WORDS)) || w_misalign;
    assign w_issue    = (r_state == ISSUE) && !w_err;
    // r_live keeps the request port closed while reset is held.
    assign w_accept   = (r_state == IDLE) && r_live && i_req_valid;

    lsu_align u_align (
        .i_size     (r_size),
        .i_off      (w_eff_addr[1:0]),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .i_rdata    (i_mem_rdata),
        .o_bmask    (w_bmask),
        .o_wdata    (w_wdata_rep),
        .o_rdata    (w_load_data)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state     <= IDLE;
            r_live      <= 1'b0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_size      <= SZ_BYTE;
            r_unsigned  <= 1'b0;
            r_wdata     <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
            if (w_accept) begin
                r_addr     <= i_req_addr;
                r_we       <= i_req_we;
                r_size     <= lsu_size_e'(i_req_size);
                r_unsigned <= i_req_unsigned;
                r_wdata    <= i_req_wdata;
            end
            if (r_state == ISSUE) begin
                r_rsp_err   <= w_err;
                r_rsp_rdata <= '0;
            end
            if (r_state == RD_WAIT) begin
                r_rsp_rdata <= w_load_data;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        o_req_ready = 1'b0;
        o_rsp_valid = 1'b0;
        o_mem_cs    = 1'b0;
        o_mem_wren  = 1'b0;
        o_mem_bmask = 4'b0000;
        case (r_state)
            IDLE: begin
                o_req_ready = r_live;
                if (w_accept) w_next = ISSUE;
            end
            ISSUE: begin
                o_mem_cs    = w_issue;
                o_mem_wren  = w_issue && r_we;
                o_mem_bmask = w_issue ? w_bmask : 4'b0000;
                w_next      = (w_err || r_we) ? RESP : RD_WAIT;
            end
            RD_WAIT: w_next = RESP;
            RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign o_mem_addr  = {2'b00, w_eff_addr[AW-1:2]};
    assign o_mem_wdata = w_wdata_rep;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_lsu_sram_ctrl.sv
// Self-checking bench for lsu_sram_ctrl: directed scenarios then random traffic
// compared with a byte-array reference model.
module tb_lsu_sram_ctrl;

    localparam int AW        = 32;
    localparam int MEM_WORDS = 16384;

    logic          clk = 1'b0;
    logic          i_reset_n = 1'b0;
    logic          i_req_valid = 1'b0;
    logic          o_req_ready;
    logic [AW-1:0] i_req_addr = '0;
    logic          i_req_we = 1'b0;
    logic [1:0]    i_req_size = 2'b00;
    logic          i_req_unsigned = 1'b0;
    logic [31:0]   i_req_wdata = '0;
    logic          o_rsp_valid;
    logic          i_rsp_ready = 1'b0;
    logic [31:0]   o_rsp_rdata;
    logic          o_rsp_err;
    logic [AW-1:0] o_mem_addr;
    logic [31:0]   o_mem_wdata;
    logic          o_mem_cs;
    logic          o_mem_wren;
    logic [3:0]    o_mem_bmask;
    logic [31:0]   i_mem_rdata = '0;

    int nchk  = 0;
    int nfail = 0;

    logic [31:0] sram    [0:MEM_WORDS-1];
    logic [7:0]  ref_mem [0:MEM_WORDS*4-1];

    always #5 clk = ~clk;

    lsu_sram_ctrl #(.AW(AW), .MEM_WORDS(MEM_WORDS)) dut (
        .i_clk          (clk),
        .i_reset_n      (i_reset_n),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_addr     (i_req_addr),
        .i_req_we       (i_req_we),
        .i_req_size     (i_req_size),
        .i_req_unsigned (i_req_unsigned),
        .i_req_wdata    (i_req_wdata),
        .o_rsp_valid    (o_rsp_valid),
        .i_rsp_ready    (i_rsp_ready),
        .o_rsp_rdata    (o_rsp_rdata),
        .o_rsp_err      (o_rsp_err),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wdata    (o_mem_wdata),
        .o_mem_cs       (o_mem_cs),
        .o_mem_wren     (o_mem_wren),
        .o_mem_bmask    (o_mem_bmask),
        .i_mem_rdata    (i_mem_rdata)
    );

    // Synchronous SRAM with one-cycle read latency and byte enables.
    always @(posedge clk) begin
        if (o_mem_cs && (o_mem_addr < MEM_WORDS)) begin
            if (o_mem_wren) begin
                for (int l = 0; l < 4; l++)
                    if (o_mem_bmask[l]) sram[o_mem_addr[13:0]][8*l +: 8] <= o_mem_wdata[8*l +: 8];
            end else begin
                i_mem_rdata <= sram[o_mem_addr[13:0]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: effective address, error and load value from the access rules.
    task automatic model(input logic [31:0] a, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] wd, output logic err,
                         output logic [31:0] rd, output logic [31:0] ea, output logic [3:0] bm);
        int n;
        logic [31:0] v;
        err = (sz == 2'b11) || ((a >> 2) >= MEM_WORDS);
        ea  = a;
`ifdef LSU_MISALIGN_TRAP_EN
        if (sz != 2'b11 && (a % (32'd1 << sz)) != 0) err = 1'b1;
`else
        if (sz != 2'b11) ea = a - (a % (32'd1 << sz));
`endif
        rd = '0;
        bm = '0;
        if (!err) begin
            n  = 1 << sz;
            bm = 4'(((1 << n) - 1) << (ea % 4));
            if (we) begin
                for (int i = 0; i < n; i++) ref_mem[ea + i] = wd[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < n; i++) v = v | (32'(ref_mem[ea + i]) << (8*i));
                if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
                rd = v;
            end
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        i_reset_n   = 1'b0;
        i_req_valid = 1'b0;
        i_rsp_ready = 1'b0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        i_reset_n = 1'b1;
    endtask

    task automatic txn(input logic [31:0] a, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] wd, input int hold, input string tag);
        logic        e_err;
        logic [31:0] e_rd, ea;
        logic [3:0]  e_bm;
        int          cs_n, lat;
        logic [31:0] c_addr, c_wd;
        logic [3:0]  c_bm;
        logic        c_wren;
        model(a, we, sz, uns, wd, e_err, e_rd, ea, e_bm);
        @(negedge clk);
        chk({tag, "/req_ready"}, 32'(o_req_ready), 32'd1);
        i_req_valid = 1'b1; i_req_addr = a; i_req_we = we; i_req_size = sz;
        i_req_unsigned = uns; i_req_wdata = wd; i_rsp_ready = 1'b0;
        @(posedge clk);
        #1 i_req_valid = 1'b0;
        cs_n = 0; lat = 0; c_addr = '0; c_wd = '0; c_bm = '0; c_wren = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (o_mem_cs) begin
                cs_n++; c_addr = o_mem_addr; c_wd = o_mem_wdata; c_bm = o_mem_bmask; c_wren = o_mem_wren;
            end
            if (o_rsp_valid) begin lat = c; break; end
            @(posedge clk);
        end
        chk({tag, "/latency"}, 32'(lat), (e_err || we) ? 32'd2 : 32'd3);
        chk({tag, "/cs_count"}, 32'(cs_n), e_err ? 32'd0 : 32'd1);
        if (cs_n == 1 && !e_err) begin
            chk({tag, "/mem_addr"}, c_addr, ea >> 2);
            chk({tag, "/bmask"}, 32'(c_bm), 32'(e_bm));
            chk({tag, "/wren"}, 32'(c_wren), 32'(we));
            if (we)
                for (int l = 0; l < 4; l++)
                    if (e_bm[l]) chk({tag, "/lane"}, 32'(c_wd[8*l +: 8]), 32'(wd[8*(l - int'(ea % 4)) +: 8]));
        end
        if (lat == 0) begin
            do_reset(2);
        end else begin
            chk({tag, "/rsp_err"}, 32'(o_rsp_err), 32'(e_err));
            chk({tag, "/rsp_rdata"}, o_rsp_rdata, e_rd);
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                @(negedge clk);
                chk({tag, "/hold_valid"}, 32'(o_rsp_valid), 32'd1);
                chk({tag, "/hold_rdata"}, o_rsp_rdata, e_rd);
                chk({tag, "/hold_err"}, 32'(o_rsp_err), 32'(e_err));
                chk({tag, "/hold_ready"}, 32'(o_req_ready), 32'd0);
            end
            i_rsp_ready = 1'b1;
            @(posedge clk);
            #1 i_rsp_ready = 1'b0;
            @(negedge clk);
            chk({tag, "/rsp_done"}, 32'(o_rsp_valid), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        int          r;
        for (int i = 0; i < MEM_WORDS; i++) sram[i] = '0;
        for (int i = 0; i < MEM_WORDS*4; i++) ref_mem[i] = '0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst/req_ready", 32'(o_req_ready), 32'd0);
        chk("rst/rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("rst/rsp_rdata", o_rsp_rdata, 32'd0);
        chk("rst/rsp_err", 32'(o_rsp_err), 32'd0);
        chk("rst/mem_cs", 32'(o_mem_cs), 32'd0);
        chk("rst/mem_wren", 32'(o_mem_wren), 32'd0);
        chk("rst/mem_bmask", 32'(o_mem_bmask), 32'd0);
        chk("rst/mem_addr", o_mem_addr, 32'd0);
        chk("rst/mem_wdata", o_mem_wdata, 32'd0);
        i_reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst/ready_after", 32'(o_req_ready), 32'd1);

        // Directed scenarios
        txn(32'h10, 1'b1, 2'b10, 1'b0, 32'hDEAD_BEEF, 0, "st_word");
        txn(32'h10, 1'b0, 2'b10, 1'b0, 32'h0, 0, "ld_word");
        txn(32'h13, 1'b1, 2'b00, 1'b0, 32'h0000_0080, 0, "st_byte");
        txn(32'h13, 1'b0, 2'b00, 1'b0, 32'h0, 0, "ld_byte_s");
        txn(32'h13, 1'b0, 2'b00, 1'b1, 32'h0, 0, "ld_byte_u");
        txn(32'h10, 1'b1, 2'b10, 1'b0, 32'h8001_7F00, 0, "st_word2");
        txn(32'h12, 1'b0, 2'b01, 1'b0, 32'h0, 0, "ld_half_s");
        txn(32'h10, 1'b0, 2'b01, 1'b1, 32'h0, 0, "ld_half_u");
        txn(32'h11, 1'b0, 2'b10, 1'b0, 32'h0, 0, "ld_misalign");
        txn(32'h13, 1'b1, 2'b01, 1'b0, 32'h0000_1234, 0, "st_half_mis");
        txn(32'h10, 1'b0, 2'b10, 1'b0, 32'h0, 5, "ld_hold5");
        txn(32'h0001_0000, 1'b0, 2'b10, 1'b0, 32'h0, 0, "ld_oor");
        txn(32'h0001_0000, 1'b1, 2'b00, 1'b0, 32'h55, 0, "st_oor");
        txn(32'h20, 1'b0, 2'b11, 1'b0, 32'h0, 0, "ld_size11");
        txn(32'h0000_FFFC, 1'b1, 2'b10, 1'b0, 32'hCAFE_F00D, 0, "st_last");
        txn(32'h0000_FFFE, 1'b0, 2'b01, 1'b0, 32'h0, 1, "ld_last");

        // Reset while waiting for read data
        @(negedge clk);
        i_req_valid = 1'b1; i_req_addr = 32'h10; i_req_we = 1'b0; i_req_size = 2'b10;
        @(posedge clk);
        #1 i_req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        i_reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rdrst/req_ready", 32'(o_req_ready), 32'd0);
        chk("rdrst/rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("rdrst/mem_cs", 32'(o_mem_cs), 32'd0);
        i_reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rdrst/ready_after", 32'(o_req_ready), 32'd1);
        chk("rdrst/no_rsp", 32'(o_rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rdrst/no_rsp2", 32'(o_rsp_valid), 32'd0);
        txn(32'h10, 1'b0, 2'b10, 1'b0, 32'h0, 0, "ld_after_rst");

        // Random traffic
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 15);
            if (r == 0)      a = 32'h0001_0000 + $urandom_range(0, 4095);
            else if (r < 10) a = $urandom_range(0, 63);
            else             a = $urandom_range(0, MEM_WORDS*4 - 1);
            sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            txn(a, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), $urandom,
                $urandom_range(0, 2), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
